// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding and bit-counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor slice: d = x - y - bin, bout = borrow.
// Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - borrow_in over
// WIDTH cycles, valid/ready handshakes on both operands and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  import serial_sub_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_subtractor u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= borrow_in;
            r_res    <= '0;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          // Result outputs update only when the final bit lands
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (done_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE) && !rst;
  assign done_valid  = (r_state == DONE);
  assign busy        = (r_state == SHIFT) || (r_state == DONE);
  assign diff        = r_diff;
  assign borrow_out  = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus
// randomized operands against an integer-arithmetic reference.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       borrow_in = 1'b0;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [7:0] diff;
  logic       borrow_out;
  logic       busy;

  logic fs_x, fs_y, fs_bin, fs_d, fs_bout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .borrow_in   (borrow_in),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .diff        (diff),
    .borrow_out  (borrow_out),
    .busy        (busy)
  );

  full_subtractor u_slice (
    .x    (fs_x),
    .y    (fs_y),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  task automatic test_slice();
    for (int i = 0; i < 8; i++) begin
      int r;
      logic [1:0] exp;
      {fs_x, fs_y, fs_bin} = 3'(i);
      #1;
      r = int'(fs_x) - int'(fs_y) - int'(fs_bin);
      exp = {r < 0, r[0]};
      n_vec++;
      if ({fs_bout, fs_d} !== exp) begin
        n_err++;
        $display("FAIL slice xyb=%0d got=%b want=%b", i,
                 {fs_bout, fs_d}, exp);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({done_valid, busy, start_ready, borrow_out, diff} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outs got dv=%b busy=%b sr=%b bo=%b diff=%h want 0",
               done_valid, busy, start_ready, borrow_out, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release start_ready got=%b want=1", start_ready);
    end
    @(negedge clk);
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ibi, input int hold,
                       input bit pulse, input string name);
    int ref_v;
    logic [7:0] e_diff;
    logic e_bo;
    int n;
    ref_v = int'(ia) - int'(ib) - int'(ibi);
    e_diff = ref_v[7:0];
    e_bo = (ref_v < 0);
    n_vec++;
    if (start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready got=%b want=1", name, start_ready);
    end
    a = ia; b = ib; borrow_in = ibi; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
    n_vec++;
    if ({busy, start_ready, done_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL %s shift_flags got=%b want=100", name,
               {busy, start_ready, done_valid});
    end
    n = 0;
    while (done_valid !== 1'b1 && n < 20) begin
      if (pulse && n == 2) begin
        a = 8'hAA; b = 8'h55; start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start_valid = 1'b0;
    n_vec++;
    if (n != 8) begin
      n_err++;
      $display("FAIL %s latency got=%0d want=8", name, n);
    end
    n_vec++;
    if (diff !== e_diff || borrow_out !== e_bo) begin
      n_err++;
      $display("FAIL %s result got=%h/%b want=%h/%b", name,
               diff, borrow_out, e_diff, e_bo);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_vec++;
      if (done_valid !== 1'b1 || diff !== e_diff || borrow_out !== e_bo
          || start_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d got dv=%b diff=%h bo=%b sr=%b", name, h,
                 done_valid, diff, borrow_out, start_ready);
      end
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    n_vec++;
    if ({done_valid, busy, start_ready} !== 3'b001 || diff !== e_diff) begin
      n_err++;
      $display("FAIL %s handshake got dv=%b busy=%b sr=%b diff=%h want 0/0/1/%h",
               name, done_valid, busy, start_ready, diff, e_diff);
    end
  endtask

  task automatic test_directed();
    do_op(8'h05, 8'h03, 1'b0, 0, 1'b0, "5m3");
    do_op(8'h03, 8'h05, 1'b0, 0, 1'b0, "3m5");
    do_op(8'h00, 8'h00, 1'b1, 1, 1'b0, "0m0b");
    do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, "FFmFF");
    do_op(8'h80, 8'h01, 1'b0, 2, 1'b0, "80m01");
  endtask

  task automatic test_backpressure();
    do_op(8'h10, 8'h01, 1'b0, 5, 1'b0, "bp");
    @(negedge clk);
    n_vec++;
    if (done_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_single got dv=%b busy=%b want 0/0", done_valid, busy);
    end
  endtask

  task automatic test_ignore_start();
    do_op(8'h05, 8'h03, 1'b0, 0, 1'b1, "ign");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), "rnd");
  endtask

  task automatic test_abort();
    int seen;
    a = 8'h77; b = 8'h11; borrow_in = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({done_valid, busy, start_ready, borrow_out, diff} !== 12'h0) begin
      n_err++;
      $display("FAIL abort_outs got dv=%b busy=%b sr=%b bo=%b diff=%h want 0",
               done_valid, busy, start_ready, borrow_out, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_no_done got=%0d active cycles want=0", seen);
    end
    do_op(8'h09, 8'h04, 1'b0, 0, 1'b0, "post_rst");
  endtask

  initial begin
    test_slice();
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes diff = a - b - borrow_in over WIDTH clock cycles using one 1-bit full-subtractor slice and a borrow flip-flop.
- Sequential counterpart to the combinational full-adder arithmetic in the college lab set.
- Operands are accepted on a valid/ready start handshake. Results are returned on a valid/ready done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operands and borrow_in are valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  initial borrow.
- done_valid  output  1  diff and borrow_out are valid; high only in DONE.
- done_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  1 iff a < b + borrow_in (unsigned).
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst is high: state = IDLE; shift registers, bit counter, borrow flop, diff and borrow_out are all 0; done_valid = 0, busy = 0.
  - start_ready = 1 as soon as rst is deasserted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready at an edge: latch a, b and borrow_in into the shift registers and the borrow flop; clear the counter; go to SHIFT.
- SHIFT:
  - Each edge processes bit i = counter, taken LSB first. With x = a[i], y = b[i], bin = borrow flop:
    - d = x ^ y ^ bin
    - bout = (~x & y) | (~(x ^ y) & bin)
  - d shifts into the MSB of the result register. The operand registers shift right. The borrow flop loads bout. The counter increments.
  - At the edge that processes bit WIDTH-1, go to DONE.
- Latency: done_valid rises exactly WIDTH cycles after the accepting edge (8 cycles at the default WIDTH).
- DONE:
  - done_valid = 1; diff = result register; borrow_out = borrow flop.
  - Outputs are held stable until done_ready is sampled high. On that edge, go to IDLE.
  - If done_ready is already high on the first DONE cycle, the block spends one cycle in DONE.
- diff and borrow_out are undefined-safe: they keep their last values in IDLE and are only qualified by done_valid.
- start_ready is 0 in SHIFT and DONE. start_valid during busy is ignored; no queueing. Operand changes while busy have no effect.
- There is no overlap between DONE and a new start. The earliest next accept is the first IDLE cycle after the done handshake.
- rst asserted mid-SHIFT or mid-DONE aborts the operation immediately. No done_valid is produced for the aborted operation.
- Arithmetic is unsigned only. Wrap-around is mod 2^WIDTH, with borrow_out carrying the sign information.
- The counter is $clog2(WIDTH) bits wide and compares against WIDTH-1; it does not rely on natural wrap.

Decomposition:
- Package serial_sub_pkg:
  - state enum/localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - counter-width function/constant.
- Sub-module full_subtractor: purely combinational 1-bit slice.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Equations as given in Behaviour; instantiated once.
  - Verified exhaustively on its own (8 input combinations) before the top level.

Test Plan:
- a=0x05, b=0x03, borrow_in=0, done_ready=1 → done_valid 8 cycles after accept; diff=0x02, borrow_out=0; start_ready returns high the next cycle.
- a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1.
- Boundary cases:
  - a=0x00, b=0x00, borrow_in=1 → diff=0xFF, borrow_out=1.
  - a=0xFF, b=0xFF, borrow_in=0 → diff=0x00, borrow_out=0.
  - a=0x80, b=0x01, borrow_in=0 → diff=0x7F, borrow_out=0.
- Backpressure: a=0x10, b=0x01, done_ready held low 5 cycles after done_valid → diff=0x0F held stable, done_valid held high; exactly one result accepted when done_ready rises.
- start_valid pulsed with a=0xAA, b=0x55 during SHIFT of 0x05 - 0x03 → ignored; start_ready=0; result is still 0x02.
- Reset mid-operation: rst asserted on cycle 4 of SHIFT → all outputs 0 asynchronously and no done_valid. After release, a=0x09, b=0x04 completes with diff=0x05.
